load_store_unit: RTL
====================

# load_store_unit

Initiator-side load/store sequencer between the pipeline MEM stage and a byte-wide, synchronous-read data memory port. Accepts one word/halfword/byte load or store per request and serialises it into 1–4 byte accesses in big-endian order (lowest address = most significant byte). Returns sign- or zero-extended load data. Back-pressures the pipeline while busy.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: byte address width on both sides.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle, request accepted when `req_valid & req_ready` at a rising edge.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_WIDTH: byte address of the access (MSB byte).
- `req_wdata` in 32: store data, right-aligned.
- `req_size` in 3: 000 word, 001 byte, 010 half, 011 byte unsigned, 100 half unsigned.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors; held until next response.
- `rsp_err` out 1: illegal request; valid with `rsp_valid`.
- `mem_en` out 1: byte access this cycle.
- `mem_we` out 1: byte write, qualified by `mem_en`.
- `mem_addr` out ADDR_WIDTH: byte address.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: read byte, valid the cycle after the edge that sampled a read.

## Operation
- States: IDLE, ACCESS, DRAIN, RESP.
- IDLE: `req_ready`=1, memory outputs 0. On accept, latch addr/size/wdata/write, set `n` = 4/2/1 for word/half/byte, and clear counter `k`. Go to ACCESS.
- Illegal requests are size 101–111, or a store with size 011/100. They go directly to RESP with `rsp_err`=1 and perform no memory access.
- ACCESS: `mem_en`=1, `mem_we`=write, `mem_addr`=base+k (modulo 2^ADDR_WIDTH, wraps silently), and `k` increments each cycle.
- Store byte order in ACCESS: `mem_wdata` = byte k of the right-aligned data, MSB first. Word order is [31:24],[23:16],[15:8],[7:0]; half is [15:8],[7:0]; byte is [7:0].
- Leaving ACCESS when k=n−1: a store goes to RESP; a load goes to DRAIN.
- Load assembly: each cycle after a read issue, `acc <= {acc[23:0], mem_rdata}`. DRAIN captures the final byte.
- RESP: `rsp_valid`=1 for exactly one cycle, then IDLE. `rsp_rdata` for loads is computed from `acc[8n-1:0]`:
  - 001 sign-extends bit 7.
  - 010 sign-extends bit 15.
  - 011 and 100 zero-extend.
  - 000 passes through.
- No alignment check: misaligned accesses are legal on a byte-wide port.
- No response back-pressure: the consumer must take `rsp_valid` when it pulses.

## Timing
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. State is IDLE.
- Let E0 be the accept edge. ACCESS occupies cycles E0..E0+n; `rsp_valid` is high:
  - Store: E0+n .. E0+n+1.
  - Load: E0+n+1 .. E0+n+2.
  - Error: E0 .. E0+1.
- Load latency to `rsp_valid`: word 5, half 3, byte 2 cycles after E0. Store latency is 4/2/1.
- `req_ready` is low from E0 until the unit returns to IDLE. The next accept is possible at the edge that ends RESP, so a back-to-back request has no bubble beyond RESP.
- Reset asserted mid-operation: immediate abort to reset values. Bytes already written stay written, and no response is issued.
- `req_*` inputs are ignored while `req_ready`=0.

## Structure
- Shared package `lsu_pkg` holds:
  - size localparams (WORD 000, BYTE 001, HALF 010, BYTE_U 011, HALF_U 100);
  - state encoding;
  - function `size_bytes(size)` returning 1/2/4, or 0 for illegal.
- The same size encoding is used by the pipeline decode.
- One combinational sub-module, `lsu_extend`, takes (size, acc) and returns the extended 32-bit result. Everything else lives in `load_store_unit`.

## Test plan
Bench memory: byte array with 1-cycle read, reset to 0.
- Word store 0xDEADBEEF at addr 8, then word load from 8: memory bytes 8..11 = DE,AD,BE,EF; `rsp_rdata`=0xDEADBEEF; load `rsp_valid` 5 cycles after accept.
- Bytes 0x80,0x01 at addr 4: half load gives 0xFFFF8001, half-unsigned gives 0x00008001, byte load at 4 gives 0xFFFFFF80, byte-unsigned gives 0x00000080.
- Word store at addr 0xFFFFFFFE: `mem_addr` sequence FFFFFFFE, FFFFFFFF, 0, 1. `rsp_err`=0.
- Store with size 011, then load with size 110: no `mem_en` cycle, `rsp_valid` the cycle after accept, `rsp_err`=1, `rsp_rdata`=0.
- `RESET_N` low during the third byte of a word store: all outputs return to reset values asynchronously; first two bytes present, last two unchanged; no `rsp_valid`.
- Back-to-back byte loads with `req_valid` held high: each accept falls at the edge ending the previous RESP; `req_ready` is never high during ACCESS or DRAIN.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store size encodings, sequencer states and size helper.
// The size encoding matches the pipeline decode.
package lsu_pkg;

    localparam logic [2:0] SZ_WORD   = 3'b000;
    localparam logic [2:0] SZ_BYTE   = 3'b001;
    localparam logic [2:0] SZ_HALF   = 3'b010;
    localparam logic [2:0] SZ_BYTE_U = 3'b011;
    localparam logic [2:0] SZ_HALF_U = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DRAIN,
        S_RESP
    } state_t;

    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            SZ_WORD:            size_bytes = 3'd4;
            SZ_BYTE, SZ_BYTE_U: size_bytes = 3'd1;
            SZ_HALF, SZ_HALF_U: size_bytes = 3'd2;
            default:            size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load bytes.
// Only the low 8n bits of acc are meaningful for an n-byte load.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [31:0] acc,
    output logic [31:0] result
);

    always_comb begin
        result = acc;
        unique case (1'b1)
            size == SZ_BYTE:   result = {{24{acc[7]}}, acc[7:0]};
            size == SZ_HALF:   result = {{16{acc[15]}}, acc[15:0]};
            size == SZ_BYTE_U: result = {24'h0, acc[7:0]};
            size == SZ_HALF_U: result = {16'h0, acc[15:0]};
            default:           result = acc;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Serialises word/half/byte loads and stores onto a byte-wide port.
// Big-endian: the lowest address carries the most significant byte.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_size,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata
);

    state_t      state;
    logic [2:0]  sz;
    logic        wr;
    logic [1:0]  k;
    logic [1:0]  last;
    logic [23:0] wsh;
    logic [23:0] acc;
    logic [31:0] acc_next;
    logic [31:0] ext;
    logic [31:0] wal;
    logic [2:0]  req_n;
    logic        accept;
    logic        illegal;

    assign accept   = req_valid & req_ready;
    assign req_n    = size_bytes(req_size);
    assign illegal  = (req_n == 3'd0) |
                      (req_write & ((req_size == SZ_BYTE_U) |
                                    (req_size == SZ_HALF_U)));
    assign acc_next = {acc, mem_rdata};

    // Left-justify store data so the first byte out is always [31:24].
    always_comb begin
        wal = req_wdata;
        unique case (1'b1)
            req_n == 3'd2: wal = {req_wdata[15:0], 16'h0};
            req_n == 3'd1: wal = {req_wdata[7:0], 24'h0};
            default:       wal = req_wdata;
        endcase
    end

    lsu_extend u_extend (
        .size   (sz),
        .acc    (acc_next),
        .result (ext)
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            sz        <= SZ_WORD;
            wr        <= 1'b0;
            k         <= 2'd0;
            last      <= 2'd0;
            wsh       <= 24'h0;
            acc       <= 24'h0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_ACCESS: begin
                    // Stale first sample shifts beyond the 8n-bit window.
                    acc <= acc_next[23:0];
                    if (k == last) begin
                        mem_en    <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= 8'h0;
                        if (wr) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b0;
                            req_ready <= 1'b1;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else begin
                        k         <= k + 2'd1;
                        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
                        mem_wdata <= wsh[23:16];
                        wsh       <= {wsh[15:0], 8'h0};
                    end
                end
                S_DRAIN: begin
                    acc       <= acc_next[23:0];
                    state     <= S_RESP;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= ext;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                end
                S_IDLE, S_RESP: begin
                    if (state == S_RESP) begin
                        state <= S_IDLE;
                    end
                    if (accept) begin
                        sz <= req_size;
                        wr <= req_write;
                        k  <= 2'd0;
                        if (illegal) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= 32'h0;
                            rsp_err   <= 1'b1;
                        end else begin
                            state     <= S_ACCESS;
                            req_ready <= 1'b0;
                            last      <= 2'(req_n - 3'd1);
                            mem_en    <= 1'b1;
                            mem_we    <= req_write;
                            mem_addr  <= req_addr;
                            mem_wdata <= wal[31:24];
                            wsh       <= wal[23:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
